// File: rtl/mmio_if.sv
// mmio_if: CPU load/store port plus RAM/VRAM side signals of the MMIO hub.
interface mmio_if;
   logic        load;
   logic        store;
   logic [2:0]  access;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [31:0] ram_rdata;
   logic        ram_we;
   logic        vram_we;
   logic [12:0] vram_waddr;
   logic [7:0]  vram_wdata;
   modport master (output load, store, access, addr, data_in, ram_rdata,
                   input data_out, ram_we, vram_we, vram_waddr, vram_wdata);
   modport slave (input load, store, access, addr, data_in, ram_rdata,
                  output data_out, ram_we, vram_we, vram_waddr, vram_wdata);
endinterface

// File: rtl/mmio_hub.sv
// mmio_hub: MMIO decoder routing CPU accesses to RAM, VRAM, keyboard FIFO, timer and LEDs.
// Define MMIO_TIMER_IRQ_EN to build the timer compare register, status and interrupt.
module mmio_hub #(
   parameter int          KBD_DEPTH = 16,
   parameter int          LED_W     = 32,
   parameter int          TICK_DIV  = 50,
   parameter logic [31:0] VRAM_BASE = 32'hFBAD0000,
   parameter int          VRAM_SIZE = 4800
) (
   input  logic             clk,
   input  logic             rst_n,
   mmio_if.slave            bus,
   input  logic             kbd_valid,
   input  logic [7:0]       kbd_byte,
   output logic [LED_W-1:0] led_data,
   output logic             timer_irq
);
   localparam int AW = $clog2(KBD_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(TICK_DIV + 1);
   logic          is_b, is_w, is_sb;
   logic          kbd_data_rd, kbd_stat_rd, cnt_rd, cnt_wr, led_wr, vram_hit;
   logic          cmp_rd, cmp_wr, tstat_rd, match;
   logic [31:0]   vram_off, cnt_ext;
   logic          empty, full, pop, push, ovf_set, tick;
   logic [7:0]    kbd_stat;
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [31:0]   cnt_q, cnt_d, cmp_q;
   logic [LED_W-1:0] led_q, led_d;
   logic [7:0]    mem_q [KBD_DEPTH];
   assign is_b        = bus.access == 3'b000 || bus.access == 3'b100;
   assign is_w        = bus.access == 3'b010;
   assign is_sb       = bus.access == 3'b000;
   assign kbd_data_rd = bus.load & is_b & (bus.addr == 32'hFBADBEEF);
   assign kbd_stat_rd = bus.load & is_b & (bus.addr == 32'hFBADBEEE);
   assign cnt_rd      = bus.load & is_w & (bus.addr == 32'hFBADBEDF);
   assign cnt_wr      = bus.store & is_w & (bus.addr == 32'hFBADBEDF);
   assign led_wr      = bus.store & is_w & (bus.addr == 32'hFBADC0FE);
   assign vram_off    = bus.addr - VRAM_BASE;
   assign vram_hit    = bus.store & is_sb & (bus.addr >= VRAM_BASE) & (vram_off < 32'(VRAM_SIZE));
   assign bus.vram_we    = vram_hit;
   assign bus.vram_waddr = vram_off[12:0];
   assign bus.vram_wdata = bus.data_in[7:0];
   assign bus.ram_we     = bus.store & ~(cnt_wr | cmp_wr | led_wr | vram_hit);
   assign led_data       = led_q;
   // A pop only happens on a non-empty FIFO; a push into a full FIFO needs a same-cycle pop.
   assign empty   = count_q == '0;
   assign full    = count_q == CW'(KBD_DEPTH);
   assign pop     = kbd_data_rd & ~empty;
   assign push    = kbd_valid & (~full | pop);
   assign ovf_set = kbd_valid & full & ~pop;
   assign cnt_ext = 32'(count_q);
   assign kbd_stat = {(cnt_ext > 32'd63) ? 6'd63 : cnt_ext[5:0], ovf_q, ~empty};
   assign tick    = pre_q == PW'(TICK_DIV - 1);
   always_comb begin
      wp_d    = push ? wp_q + 1'b1 : wp_q;
      rp_d    = pop ? rp_q + 1'b1 : rp_q;
      count_d = count_q + CW'(push) - CW'(pop);
      ovf_d   = ovf_set | (ovf_q & ~kbd_stat_rd);
      pre_d   = (cnt_wr | tick) ? '0 : pre_q + 1'b1;
      cnt_d   = cnt_wr ? bus.data_in : tick ? cnt_q + 32'd1 : cnt_q;
      led_d   = led_wr ? bus.data_in[LED_W-1:0] : led_q;
   end
   always_comb begin
      bus.data_out = bus.ram_rdata;
      if (kbd_data_rd)   bus.data_out = {24'b0, empty ? 8'h00 : mem_q[rp_q]};
      else if (kbd_stat_rd) bus.data_out = {24'b0, kbd_stat};
      else if (cnt_rd)   bus.data_out = cnt_q;
      else if (cmp_rd)   bus.data_out = cmp_q;
      else if (tstat_rd) bus.data_out = {31'b0, match};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         pre_q   <= '0;
         cnt_q   <= '0;
         led_q   <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
      end
   end
   always_ff @(posedge clk) if (push) mem_q[wp_q] <= kbd_byte;
`ifdef MMIO_TIMER_IRQ_EN
   logic [31:0] cmp_d;
   logic        match_q, match_d;
   assign cmp_rd   = bus.load & is_w & (bus.addr == 32'hFBADBED8);
   assign cmp_wr   = bus.store & is_w & (bus.addr == 32'hFBADBED8);
   assign tstat_rd = bus.load & is_w & (bus.addr == 32'hFBADBED4);
   assign match    = match_q;
   assign timer_irq = match_q;
   // A same-cycle match set wins over the clear-on-read.
   always_comb begin
      cmp_d   = cmp_wr ? bus.data_in : cmp_q;
      match_d = (~cnt_wr & tick & (cnt_q + 32'd1 == cmp_q)) | (match_q & ~tstat_rd);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_q   <= 32'hFFFFFFFF;
         match_q <= 1'b0;
      end else begin
         cmp_q   <= cmp_d;
         match_q <= match_d;
      end
   end
`else
   assign cmp_rd    = 1'b0;
   assign cmp_wr    = 1'b0;
   assign tstat_rd  = 1'b0;
   assign match     = 1'b0;
   assign cmp_q     = 32'hFFFFFFFF;
   assign timer_irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: directed vectors with hand-computed expectations for mmio_hub.
module tb_mmio_hub;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       kbd_valid = 1'b0;
   logic [7:0] kbd_byte = 8'h00;
   logic [31:0] led_data;
   logic       timer_irq;
   int         vectors = 0;
   int         errs = 0;
   logic [31:0] rv;
   localparam logic [31:0] RAMV = 32'h5A5A5A5A;
   mmio_if bus ();
   mmio_hub dut (.clk(clk), .rst_n(rst_n), .bus(bus), .kbd_valid(kbd_valid), .kbd_byte(kbd_byte),
                 .led_data(led_data), .timer_irq(timer_irq));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic clk1();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.load = 1'b0;
      bus.store = 1'b0;
      bus.access = 3'b000;
      bus.addr = 32'h0;
      bus.data_in = 32'h0;
      kbd_valid = 1'b0;
   endtask
   task automatic push(input logic [7:0] b);
      kbd_valid = 1'b1;
      kbd_byte = b;
      clk1();
      kbd_valid = 1'b0;
   endtask
   task automatic rd(input logic [31:0] a, input logic [2:0] acc, output logic [31:0] d);
      bus.load = 1'b1;
      bus.addr = a;
      bus.access = acc;
      #1 d = bus.data_out;
      clk1();
      bus.load = 1'b0;
   endtask
   task automatic wr(input logic [31:0] a, input logic [2:0] acc, input logic [31:0] d);
      bus.store = 1'b1;
      bus.addr = a;
      bus.access = acc;
      bus.data_in = d;
      clk1();
      bus.store = 1'b0;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      idle();
      bus.ram_rdata = RAMV;
      repeat (2) clk1();
      chk("rst_led", led_data, 32'h0);
      chk("rst_irq", {31'b0, timer_irq}, 32'h0);
      chk("rst_ram_we", {31'b0, bus.ram_we}, 32'h0);
      chk("rst_vram_we", {31'b0, bus.vram_we}, 32'h0);
      rst_n = 1'b1;
      clk1();
      rd(32'hFBADBEEE, 3'b100, rv); chk("rst_kbd_stat", rv, 32'h0);
      rd(32'hFBADBEDF, 3'b010, rv); chk("rst_cnt", rv, 32'h0);
      // keyboard FIFO order and empty read
      push(8'hA1); push(8'hB2); push(8'hC3);
      rd(32'hFBADBEEF, 3'b100, rv); chk("kbd_a1", rv, 32'hA1);
      rd(32'hFBADBEEF, 3'b000, rv); chk("kbd_b2", rv, 32'hB2);
      rd(32'hFBADBEEF, 3'b100, rv); chk("kbd_c3", rv, 32'hC3);
      rd(32'hFBADBEEF, 3'b100, rv); chk("kbd_empty", rv, 32'h0);
      rd(32'hFBADBEEE, 3'b100, rv); chk("kbd_stat0", rv, 32'h0);
      rd(32'hFBADBEEF, 3'b010, rv); chk("kbd_lw_ram", rv, RAMV);
      // overflow
      for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
      rd(32'hFBADBEEE, 3'b100, rv); chk("kbd_stat_ovf", rv, 32'h43);
      rd(32'hFBADBEEE, 3'b100, rv); chk("kbd_stat_clr", rv, 32'h41);
      // full with push and pop together
      kbd_valid = 1'b1; kbd_byte = 8'hEE;
      rd(32'hFBADBEEF, 3'b100, rv); chk("full_pushpop", rv, 32'h10);
      kbd_valid = 1'b0;
      rd(32'hFBADBEEE, 3'b100, rv); chk("full_stat", rv, 32'h41);
      for (int i = 0; i < 15; i++) begin
         rd(32'hFBADBEEF, 3'b100, rv); chk("drain", rv, 32'(8'h11 + i));
      end
      rd(32'hFBADBEEF, 3'b100, rv); chk("drain_ee", rv, 32'hEE);
      rd(32'hFBADBEEE, 3'b100, rv); chk("drain_stat", rv, 32'h0);
      // empty with push and pop together
      kbd_valid = 1'b1; kbd_byte = 8'h5C;
      rd(32'hFBADBEEF, 3'b100, rv); chk("empty_pushpop", rv, 32'h0);
      kbd_valid = 1'b0;
      rd(32'hFBADBEEE, 3'b100, rv); chk("empty_pp_stat", rv, 32'h05);
      rd(32'hFBADBEEF, 3'b100, rv); chk("empty_pp_byte", rv, 32'h5C);
      // timer
      wr(32'hFBADBEDF, 3'b010, 32'h0);
      repeat (500) clk1();
      rd(32'hFBADBEDF, 3'b010, rv); chk("timer_10", rv, 32'd10);
      rd(32'hFBADBEDF, 3'b000, rv); chk("timer_lb_ram", rv, RAMV);
      wr(32'hFBADBEDF, 3'b010, 32'hFFFFFFFF);
      repeat (50) clk1();
      rd(32'hFBADBEDF, 3'b010, rv); chk("timer_wrap", rv, 32'h0);
`ifdef MMIO_TIMER_IRQ_EN
      rd(32'hFBADBED8, 3'b010, rv); chk("cmp_rst", rv, 32'hFFFFFFFF);
      wr(32'hFBADBED8, 3'b010, 32'd5);
      wr(32'hFBADBEDF, 3'b010, 32'h0);
      repeat (249) clk1();
      chk("irq_before", {31'b0, timer_irq}, 32'h0);
      clk1();
      chk("irq_rise", {31'b0, timer_irq}, 32'h1);
      rd(32'hFBADBED4, 3'b010, rv); chk("tstat", rv, 32'h1);
      chk("irq_clr", {31'b0, timer_irq}, 32'h0);
`else
      rd(32'hFBADBED4, 3'b010, rv); chk("tstat_ram", rv, RAMV);
      bus.store = 1'b1; bus.access = 3'b010; bus.addr = 32'hFBADBED8;
      #1 chk("cmp_wr_ram", {31'b0, bus.ram_we}, 32'h1);
      clk1(); bus.store = 1'b0;
      chk("irq_tied", {31'b0, timer_irq}, 32'h0);
`endif
      // VRAM window and LED
      bus.store = 1'b1; bus.access = 3'b000; bus.addr = 32'hFBAD12BF; bus.data_in = 32'h7E;
      #1;
      chk("vram_we", {31'b0, bus.vram_we}, 32'h1);
      chk("vram_waddr", {19'b0, bus.vram_waddr}, 32'h12BF);
      chk("vram_wdata", {24'b0, bus.vram_wdata}, 32'h7E);
      chk("vram_ram_we", {31'b0, bus.ram_we}, 32'h0);
      bus.addr = 32'hFBAD12C0;
      #1;
      chk("vram_end_ram", {31'b0, bus.ram_we}, 32'h1);
      chk("vram_end_vwe", {31'b0, bus.vram_we}, 32'h0);
      bus.addr = 32'hFBADBEEF;
      #1 chk("ro_store_ram", {31'b0, bus.ram_we}, 32'h1);
      bus.access = 3'b010; bus.addr = 32'hFBADC0FE; bus.data_in = 32'h5;
      #1 chk("led_ram_we", {31'b0, bus.ram_we}, 32'h0);
      clk1(); bus.store = 1'b0;
      chk("led_data", led_data, 32'h5);
      // reset mid-operation
      push(8'h33); push(8'h44);
      rst_n = 1'b0;
      #2 chk("arst_led", led_data, 32'h0);
      rst_n = 1'b1;
      clk1();
      rd(32'hFBADBEEE, 3'b100, rv); chk("arst_stat", rv, 32'h0);
      rd(32'hFBADBEEF, 3'b100, rv); chk("arst_data", rv, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
